serial_pattern_tx: RTL and testbench

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

---
 rtl/serial_pattern_tx.sv | 129 ++++++++++++
 tb/tb_serial_pattern_tx.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: MSB-first parallel-to-serial shifter with
// back-to-back word chaining and an overlapping "101" detector.
//
// Ports:
//   clock     - single clock, rising-edge state updates
//   reset     - synchronous, active-high
//   data_in   - WIDTH-bit word to serialize
//   load      - data_in valid; taken on an edge where ready=1
//   ready     - a word can be accepted this cycle
//   out       - serial bit stream, MSB first
//   out_valid - out carries a stream bit this cycle
//   done      - pulse with the last bit of each word
//   exp_count - saturating count of "101" in the valid-bit stream
module serial_pattern_tx #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             out,
   output logic             out_valid,
   output logic             done,
   output logic [CNT_W-1:0] exp_count
);

   localparam int BC_W = $clog2(WIDTH) + 1;
   localparam logic [BC_W-1:0] LAST = BC_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (WIDTH < 2) begin : g_bad_width
      $error("serial_pattern_tx: WIDTH must be >= 2");
   end

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nx;
   logic [BC_W-1:0]  bit_cnt;
   logic [BC_W-1:0]  bit_cnt_nx;
   logic [1:0]       hist;
   logic [1:0]       hist_nx;
   logic [CNT_W-1:0] cnt_nx;
   logic             last_bit;
   logic             hit;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         hist      <= 2'b00;
         exp_count <= '0;
      end else begin
         state     <= state_nx;
         shreg     <= shreg_nx;
         bit_cnt   <= bit_cnt_nx;
         hist      <= hist_nx;
         exp_count <= cnt_nx;
      end
   end

   // Outputs depend only on state, shreg and bit_cnt, so load and
   // data_in never reach an output combinationally.
   always_comb begin
      state_nx   = state;
      shreg_nx   = shreg;
      bit_cnt_nx = bit_cnt;
      hist_nx    = hist;
      cnt_nx     = exp_count;
      ready      = 1'b0;
      out        = 1'b0;
      out_valid  = 1'b0;
      done       = 1'b0;
      last_bit   = 1'b0;
      hit        = 1'b0;

      unique case (state)
         IDLE: begin
            ready = 1'b1;
            if (load) begin
               shreg_nx   = data_in;
               bit_cnt_nx = '0;
               state_nx   = SHIFT;
            end
         end
         SHIFT: begin
            out       = shreg[WIDTH-1];
            out_valid = 1'b1;
            last_bit  = (bit_cnt == LAST);
            done      = last_bit;
            ready     = last_bit;

            // hist[1] is the older bit: "10" then a 1 closes "101".
            // History only moves on valid bits, so it spans words
            // and idle gaps.
            hit     = (hist == 2'b10) && out;
            hist_nx = {hist[0], out};
            if (hit && (exp_count != CNT_MAX)) begin
               cnt_nx = exp_count + 1'b1;
            end

            if (last_bit) begin
               // Chaining on the last bit keeps out_valid high with
               // no bubble between words.
               if (load) begin
                  shreg_nx   = data_in;
                  bit_cnt_nx = '0;
               end else begin
                  shreg_nx   = shreg << 1;
                  bit_cnt_nx = '0;
                  state_nx   = IDLE;
               end
            end else begin
               shreg_nx   = shreg << 1;
               bit_cnt_nx = bit_cnt + 1'b1;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: scoreboard bench for serial_pattern_tx,
// one full-width counter instance and one 2-bit saturating one.
module tb_serial_pattern_tx;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [7:0]  data_in = 8'h00;

   logic        ready, out, out_valid, done;
   logic [15:0] exp_count;
   logic        ready2, out2, out_valid2, done2;
   logic [1:0]  exp_count2;

   int checks = 0;
   int failures = 0;
   bit mon_en = 1'b0;

   typedef struct packed {
      logic b;
      logic last;
   } ent_t;

   ent_t        q[$];
   logic [1:0]  mh = 2'b00;
   logic [15:0] mcnt = '0;
   logic [1:0]  mcnt2 = '0;

   serial_pattern_tx #(.WIDTH(8), .CNT_W(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .data_in   (data_in),
      .load      (load),
      .ready     (ready),
      .out       (out),
      .out_valid (out_valid),
      .done      (done),
      .exp_count (exp_count)
   );

   serial_pattern_tx #(.WIDTH(8), .CNT_W(2)) dut_sat (
      .clock     (clock),
      .reset     (reset),
      .data_in   (data_in),
      .load      (load),
      .ready     (ready2),
      .out       (out2),
      .out_valid (out_valid2),
      .done      (done2),
      .exp_count (exp_count2)
   );

   always #5 clock = ~clock;

   task automatic drive(input logic ld, input logic [7:0] d,
                        input logic rst);
      @(negedge clock);
      #1;
      reset   = rst;
      load    = ld;
      data_in = d;
      if (rst) begin
         q.delete();
         mh    = 2'b00;
         mcnt  = '0;
         mcnt2 = '0;
      end else if (ld && q.size() == 0) begin
         for (int i = 7; i >= 0; i--) begin
            q.push_back('{b: d[i], last: (i == 0)});
         end
      end
   endtask

   task automatic monitor();
      ent_t e;
      logic ev;
      logic er;
      forever begin
         @(negedge clock);
         if (mon_en) begin
            ev = (q.size() != 0);
            e  = ev ? q[0] : '0;
            er = (q.size() <= 1);
            checks += 1;
            if (out_valid !== ev) begin
               failures += 1;
               $display("FAIL out_valid: got %b want %b t=%0t",
                        out_valid, ev, $time);
            end
            checks += 1;
            if (out !== e.b) begin
               failures += 1;
               $display("FAIL out: got %b want %b t=%0t",
                        out, e.b, $time);
            end
            checks += 1;
            if (done !== e.last) begin
               failures += 1;
               $display("FAIL done: got %b want %b t=%0t",
                        done, e.last, $time);
            end
            checks += 1;
            if (ready !== er) begin
               failures += 1;
               $display("FAIL ready: got %b want %b t=%0t",
                        ready, er, $time);
            end
            checks += 1;
            if (exp_count !== mcnt) begin
               failures += 1;
               $display("FAIL exp_count: got %0d want %0d t=%0t",
                        exp_count, mcnt, $time);
            end
            checks += 1;
            if ({out_valid2, out2, done2, ready2} !==
                {ev, e.b, e.last, er}) begin
               failures += 1;
               $display("FAIL sat_outputs: got %b want %b t=%0t",
                        {out_valid2, out2, done2, ready2},
                        {ev, e.b, e.last, er}, $time);
            end
            checks += 1;
            if (exp_count2 !== mcnt2) begin
               failures += 1;
               $display("FAIL sat_count: got %0d want %0d t=%0t",
                        exp_count2, mcnt2, $time);
            end
            if (ev) begin
               if (mh == 2'b10 && e.b) begin
                  if (mcnt != 16'hFFFF) mcnt = mcnt + 1'b1;
                  if (mcnt2 != 2'd3) mcnt2 = mcnt2 + 1'b1;
               end
               mh = {mh[0], e.b};
               void'(q.pop_front());
            end
         end
      end
   endtask

   task automatic test_reset();
      drive(1'b0, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b0);
      mon_en = 1'b1;
      checks += 1;
      if ({ready, out_valid, out, done} !== 4'b1000) begin
         failures += 1;
         $display("FAIL reset_outputs: got %b want 1000",
                  {ready, out_valid, out, done});
      end
      checks += 1;
      if (exp_count !== 16'd0 || exp_count2 !== 2'd0) begin
         failures += 1;
         $display("FAIL reset_count: got %0d/%0d want 0/0",
                  exp_count, exp_count2);
      end
   endtask

   task automatic test_single();
      logic [7:0] got;
      int nd;
      int nv;
      got = '0;
      nd  = 0;
      nv  = 0;
      drive(1'b1, 8'hA5, 1'b0);
      for (int j = 1; j <= 8; j++) begin
         drive(1'b0, 8'h00, 1'b0);
         got = {got[6:0], out};
         nd += int'(done);
         nv += int'(out_valid);
         checks += 1;
         if (done !== (j == 8)) begin
            failures += 1;
            $display("FAIL single_done_pos: got %b at bit %0d",
                     done, j);
         end
      end
      drive(1'b0, 8'h00, 1'b0);
      checks += 1;
      if (got !== 8'hA5 || nv != 8 || nd != 1) begin
         failures += 1;
         $display("FAIL single_stream: got %h v%0d d%0d want a5 v8 d1",
                  got, nv, nd);
      end
      checks += 1;
      if (exp_count !== 16'd2 || out_valid !== 1'b0 ||
          ready !== 1'b1) begin
         failures += 1;
         $display("FAIL single_end: got cnt %0d v%b r%b want 2 0 1",
                  exp_count, out_valid, ready);
      end
   endtask

   task automatic test_overlap();
      logic [7:0] got;
      got = '0;
      drive(1'b1, 8'hAA, 1'b0);
      for (int j = 1; j <= 8; j++) begin
         drive(1'b0, 8'h00, 1'b0);
         got = {got[6:0], out};
      end
      drive(1'b0, 8'h00, 1'b0);
      checks += 1;
      if (got !== 8'hAA || exp_count !== 16'd3) begin
         failures += 1;
         $display("FAIL overlap: got %h cnt %0d want aa cnt 3",
                  got, exp_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] got;
      int nd;
      int nv;
      got = '0;
      nd  = 0;
      nv  = 0;
      drive(1'b1, 8'h01, 1'b0);
      for (int j = 1; j <= 16; j++) begin
         if (j < 8) drive(1'b1, 8'h01, 1'b0);
         else if (j == 8) drive(1'b1, 8'h40, 1'b0);
         else drive(1'b0, 8'h00, 1'b0);
         got = {got[14:0], out};
         nd += int'(done);
         nv += int'(out_valid);
      end
      drive(1'b0, 8'h00, 1'b0);
      checks += 1;
      if (got !== 16'h0140 || nv != 16 || nd != 2) begin
         failures += 1;
         $display("FAIL b2b_stream: got %h v%0d d%0d want 0140 v16 d2",
                  got, nv, nd);
      end
      checks += 1;
      if (exp_count !== 16'd1 || out_valid !== 1'b0) begin
         failures += 1;
         $display("FAIL b2b_count: got %0d v%b want 1 0",
                  exp_count, out_valid);
      end
   endtask

   task automatic test_busy();
      logic [7:0] got;
      int nd;
      got = '0;
      nd  = 0;
      drive(1'b1, 8'hA5, 1'b0);
      for (int j = 1; j <= 8; j++) begin
         if (j == 3) drive(1'b1, 8'hFF, 1'b0);
         else drive(1'b0, 8'h00, 1'b0);
         got = {got[6:0], out};
         nd += int'(done);
      end
      drive(1'b0, 8'h00, 1'b0);
      checks += 1;
      if (got !== 8'hA5 || nd != 1 || exp_count !== 16'd2 ||
          out_valid !== 1'b0) begin
         failures += 1;
         $display("FAIL busy: got %h d%0d cnt %0d v%b want a5 1 2 0",
                  got, nd, exp_count, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] got;
      int nd;
      got = '0;
      nd  = 0;
      drive(1'b1, 8'hA5, 1'b0);
      for (int j = 1; j <= 3; j++) drive(1'b0, 8'h00, 1'b0);
      drive(1'b0, 8'h00, 1'b1);
      for (int j = 0; j < 3; j++) begin
         drive(1'b0, 8'h00, 1'b0);
         nd += int'(done);
         checks += 1;
         if (out_valid !== 1'b0 || exp_count !== 16'd0) begin
            failures += 1;
            $display("FAIL mid_reset: got v%b cnt %0d want 0 0",
                     out_valid, exp_count);
         end
      end
      checks += 1;
      if (nd != 0) begin
         failures += 1;
         $display("FAIL mid_reset_done: got %0d pulses want 0", nd);
      end
      drive(1'b1, 8'hAA, 1'b0);
      for (int j = 1; j <= 8; j++) begin
         drive(1'b0, 8'h00, 1'b0);
         got = {got[6:0], out};
      end
      drive(1'b0, 8'h00, 1'b0);
      checks += 1;
      if (got !== 8'hAA || exp_count !== 16'd3) begin
         failures += 1;
         $display("FAIL after_reset: got %h cnt %0d want aa 3",
                  got, exp_count);
      end
   endtask

   task automatic test_saturation();
      logic [15:0] got;
      got = '0;
      drive(1'b1, 8'hAA, 1'b0);
      for (int j = 1; j <= 16; j++) begin
         if (j == 8) drive(1'b1, 8'hAA, 1'b0);
         else drive(1'b0, 8'h00, 1'b0);
         got = {got[14:0], out2};
      end
      drive(1'b0, 8'h00, 1'b0);
      checks += 1;
      if (got !== 16'hAAAA || exp_count !== 16'd7 ||
          exp_count2 !== 2'd3) begin
         failures += 1;
         $display("FAIL saturate: got %h %0d/%0d want aaaa 7/3",
                  got, exp_count, exp_count2);
      end
      for (int j = 0; j < 3; j++) drive(1'b0, 8'h00, 1'b0);
      checks += 1;
      if (exp_count2 !== 2'd3) begin
         failures += 1;
         $display("FAIL saturate_hold: got %0d want 3", exp_count2);
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_single();
      test_reset();
      test_overlap();
      test_reset();
      test_back_to_back();
      test_reset();
      test_busy();
      test_reset();
      test_reset_mid();
      test_reset();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
